// File: rtl/dwtlb_ctrl.sv
// Lookup sequencer for the 4-way data write TLB: round-robin read-port arbitration,
// miss handling through the page walker, victim fill, replay and whole-TLB flush.
module dwtlb_ctrl #(
   parameter int IP_WIDTH   = 50,
   parameter int DATA_WIDTH = 64,   // matches dtlbData_width in the core build
   parameter int SETS       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_en,
   input  logic                  req1_en,
   input  logic [IP_WIDTH-1:0]   req0_addr,
   input  logic [IP_WIDTH-1:0]   req1_addr,
   output logic                  req0_gnt,
   output logic                  req1_gnt,
   output logic                  tlb_read_clkEn,
   output logic [IP_WIDTH-1:0]   tlb_addr,
   input  logic [3:0]            tlb_hit,
   input  logic [7:0]            tlb_lru,
   output logic                  tlb_write_wen,
   output logic [1:0]            tlb_write_way,
   output logic [DATA_WIDTH-1:0] tlb_write_data0,
   output logic [DATA_WIDTH-1:0] tlb_write_data1,
   output logic                  tlb_inval_en,
   output logic [$clog2(SETS)-1:0] tlb_inval_set,
   output logic                  walk_req,
   output logic [IP_WIDTH-1:0]   walk_addr,
   input  logic                  walk_ack,
   input  logic                  walk_rsp_valid,
   input  logic [DATA_WIDTH-1:0] walk_rsp_data0,
   input  logic [DATA_WIDTH-1:0] walk_rsp_data1,
   input  logic                  walk_rsp_fault,
   input  logic                  flush,
   output logic                  flush_done,
   output logic                  rsp_valid,
   output logic                  rsp_port,
   output logic                  rsp_fault,
   output logic                  busy
);

   localparam int SET_W = $clog2(SETS);

   typedef enum logic [2:0] {IDLE, WALK_REQ, WALK_WAIT, FILL, REPLAY, FLUSH} state_t;

   state_t                state_q, state_d;
   logic                  rr_q;
   logic                  s2_valid_q, s2_port_q;
   logic [IP_WIDTH-1:0]   s2_addr_q;
   logic [IP_WIDTH-1:0]   miss_addr_q;
   logic                  miss_port_q;
   logic [7:0]            lru_q;
   logic [DATA_WIDTH-1:0] data0_q, data1_q;
   logic                  flush_pend_q, flush_done_q;
   logic [SET_W-1:0]      flush_cnt_q;

   logic       s2_hit, s2_miss, flush_req;
   logic       grant, gnt_port, take_rsp;
   logic [1:0] victim;

   assign s2_hit    = s2_valid_q & (|tlb_hit);
   assign s2_miss   = s2_valid_q & ~(|tlb_hit);
   assign flush_req = flush | flush_pend_q;

   // Victim is the lowest-index way whose LRU field is zero, scanning from the top so the lowest wins.
   always_comb begin
      victim = 2'd0;
      for (int w = 3; w >= 0; w--)
         if (lru_q[2*w +: 2] == 2'b00) victim = w[1:0];
   end

   // NOTE: every output gets a default before the case so no path leaves a latch behind.
   always_comb begin
      state_d         = state_q;
      grant           = 1'b0;
      gnt_port        = 1'b0;
      take_rsp        = 1'b0;
      tlb_read_clkEn  = 1'b0;
      tlb_addr        = '0;
      tlb_write_wen   = 1'b0;
      tlb_write_way   = 2'd0;
      tlb_write_data0 = '0;
      tlb_write_data1 = '0;
      tlb_inval_en    = 1'b0;
      tlb_inval_set   = '0;
      walk_req        = 1'b0;
      walk_addr       = '0;
      rsp_valid       = s2_hit;
      rsp_port        = s2_port_q;
      rsp_fault       = 1'b0;

      case (state_q)
         IDLE: begin
            if (s2_miss) begin
               state_d = WALK_REQ;
            end else if (flush_req) begin
               state_d = FLUSH;
            end else if (req0_en || req1_en) begin
               grant    = 1'b1;
               gnt_port = (req0_en && req1_en) ? ~rr_q : req1_en;
            end
         end
         WALK_REQ: begin
            walk_req  = 1'b1;
            walk_addr = miss_addr_q;
            if (walk_ack) begin
               if (walk_rsp_valid) take_rsp = 1'b1;
               else                state_d  = WALK_WAIT;
            end
         end
         WALK_WAIT: take_rsp = walk_rsp_valid;
         FILL: begin
            tlb_write_wen   = 1'b1;
            tlb_write_way   = victim;
            tlb_write_data0 = data0_q;
            tlb_write_data1 = data1_q;
            tlb_addr        = miss_addr_q;
            state_d         = REPLAY;
         end
         REPLAY: begin
            tlb_read_clkEn = 1'b1;
            tlb_addr       = miss_addr_q;
            state_d        = IDLE;
         end
         FLUSH: begin
            tlb_inval_en  = 1'b1;
            tlb_inval_set = flush_cnt_q;
            if (flush_cnt_q == SET_W'(SETS - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (take_rsp) begin
         if (walk_rsp_fault) begin
            rsp_valid = 1'b1;
            rsp_fault = 1'b1;
            rsp_port  = miss_port_q;
            state_d   = IDLE;
         end else begin
            state_d = FILL;
         end
      end

      if (grant) begin
         tlb_read_clkEn = 1'b1;
         tlb_addr       = gnt_port ? req1_addr : req0_addr;
      end
   end

   assign req0_gnt   = grant & ~gnt_port;
   assign req1_gnt   = grant & gnt_port;
   assign flush_done = flush_done_q;
   assign busy       = (state_q != IDLE);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_port_q    <= 1'b0;
         s2_addr_q    <= '0;
         miss_addr_q  <= '0;
         miss_port_q  <= 1'b0;
         lru_q        <= '0;
         data0_q      <= '0;
         data1_q      <= '0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
         flush_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         s2_valid_q <= grant | (state_q == REPLAY);
         s2_port_q  <= grant ? gnt_port : miss_port_q;
         s2_addr_q  <= tlb_addr;
         if (grant) rr_q <= gnt_port;
         // LRU is snapshotted at the miss; later lookups may move it before the fill.
         if (state_q == IDLE && s2_miss) begin
            miss_addr_q <= s2_addr_q;
            miss_port_q <= s2_port_q;
            lru_q       <= tlb_lru;
         end
         if (take_rsp && !walk_rsp_fault) begin
            data0_q <= walk_rsp_data0;
            data1_q <= walk_rsp_data1;
         end
         if (state_q == IDLE && state_d == FLUSH) flush_pend_q <= 1'b0;
         else if (flush)                          flush_pend_q <= 1'b1;
         if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + SET_W'(1);
         flush_done_q <= (state_q == FLUSH) && (flush_cnt_q == SET_W'(SETS - 1));
      end
   end

endmodule

// File: tb/tb_dwtlb_ctrl.sv
// Directed bench for dwtlb_ctrl: arbitration vector table plus hand-written
// miss, fault, victim-selection, flush and mid-walk reset sequences.
module tb_dwtlb_ctrl;

   localparam int IW = 50;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_en, req1_en;
   logic [IW-1:0] req0_addr, req1_addr;
   logic          req0_gnt, req1_gnt;
   logic          tlb_read_clkEn;
   logic [IW-1:0] tlb_addr;
   logic [3:0]    tlb_hit;
   logic [7:0]    tlb_lru;
   logic          tlb_write_wen;
   logic [1:0]    tlb_write_way;
   logic [DW-1:0] tlb_write_data0, tlb_write_data1;
   logic          tlb_inval_en;
   logic [4:0]    tlb_inval_set;
   logic          walk_req;
   logic [IW-1:0] walk_addr;
   logic          walk_ack, walk_rsp_valid, walk_rsp_fault;
   logic [DW-1:0] walk_rsp_data0, walk_rsp_data1;
   logic          flush, flush_done;
   logic          rsp_valid, rsp_port, rsp_fault, busy;

   int passed = 0;
   int total  = 0;

   dwtlb_ctrl #(.IP_WIDTH(IW), .DATA_WIDTH(DW), .SETS(32)) dut (
      .clk(clk), .rst(rst),
      .req0_en(req0_en), .req1_en(req1_en),
      .req0_addr(req0_addr), .req1_addr(req1_addr),
      .req0_gnt(req0_gnt), .req1_gnt(req1_gnt),
      .tlb_read_clkEn(tlb_read_clkEn), .tlb_addr(tlb_addr),
      .tlb_hit(tlb_hit), .tlb_lru(tlb_lru),
      .tlb_write_wen(tlb_write_wen), .tlb_write_way(tlb_write_way),
      .tlb_write_data0(tlb_write_data0), .tlb_write_data1(tlb_write_data1),
      .tlb_inval_en(tlb_inval_en), .tlb_inval_set(tlb_inval_set),
      .walk_req(walk_req), .walk_addr(walk_addr), .walk_ack(walk_ack),
      .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data0(walk_rsp_data0),
      .walk_rsp_data1(walk_rsp_data1), .walk_rsp_fault(walk_rsp_fault),
      .flush(flush), .flush_done(flush_done),
      .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_fault(rsp_fault), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Advance one cycle; single-cycle pulses return to zero, request levels persist.
   task automatic next();
      @(posedge clk);
      #1;
      tlb_hit        = 4'b0;
      walk_ack       = 1'b0;
      walk_rsp_valid = 1'b0;
      walk_rsp_fault = 1'b0;
      flush          = 1'b0;
   endtask

   typedef struct {
      logic       r0, r1;
      logic [3:0] hit;
      logic       g0, g1, rv, rp;
   } vec_t;

   vec_t vecs[10];

   localparam logic [IW-1:0] A0 = 50'h0_0000_0000_0A00;
   localparam logic [IW-1:0] A1 = 50'h0_0000_0000_0B11;

   initial begin
      // Round-robin table: rr starts at 0 so port 1 wins the first tie.
      vecs[0] = '{1, 1, 4'b0000, 0, 1, 0, 0};
      vecs[1] = '{1, 1, 4'b0001, 1, 0, 1, 1};
      vecs[2] = '{1, 1, 4'b0100, 0, 1, 1, 0};
      vecs[3] = '{1, 1, 4'b1000, 1, 0, 1, 1};
      vecs[4] = '{0, 0, 4'b0010, 0, 0, 1, 0};
      vecs[5] = '{1, 0, 4'b0000, 1, 0, 0, 0};
      vecs[6] = '{0, 1, 4'b0001, 0, 1, 1, 0};
      vecs[7] = '{0, 1, 4'b0001, 0, 1, 1, 1};
      vecs[8] = '{1, 1, 4'b0001, 1, 0, 1, 1};
      vecs[9] = '{0, 0, 4'b0001, 0, 0, 1, 0};

      rst = 1'b0;
      req0_en = 0; req1_en = 0; req0_addr = A0; req1_addr = A1;
      tlb_hit = 0; tlb_lru = 0; walk_ack = 0; walk_rsp_valid = 0; walk_rsp_fault = 0;
      walk_rsp_data0 = 0; walk_rsp_data1 = 0; flush = 0;

      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset walk_req", walk_req, 0);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset inval_en", tlb_inval_en, 0);
      check("reset flush_done", flush_done, 0);
      rst = 1'b1;

      // ---- arbitration table ----
      for (int i = 0; i < 10; i++) begin
         req0_en = vecs[i].r0; req1_en = vecs[i].r1; tlb_hit = vecs[i].hit;
         @(negedge clk);
         check($sformatf("v%0d gnt0", i), req0_gnt, vecs[i].g0);
         check($sformatf("v%0d gnt1", i), req1_gnt, vecs[i].g1);
         check($sformatf("v%0d clkEn", i), tlb_read_clkEn, vecs[i].g0 | vecs[i].g1);
         if (vecs[i].g0 | vecs[i].g1)
            check($sformatf("v%0d tlb_addr", i), tlb_addr, vecs[i].g1 ? A1 : A0);
         check($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].rv);
         if (vecs[i].rv) check($sformatf("v%0d rsp_port", i), rsp_port, vecs[i].rp);
         next();
      end
      req0_en = 0; req1_en = 0;

      // ---- miss on port 0, delayed ack, fill of way 1, replay hit ----
      req0_en = 1; req0_addr = 50'h1234;
      @(negedge clk); check("miss grant0", req0_gnt, 1);
      next();
      req0_en = 0; req1_en = 1; tlb_lru = 8'b11_10_00_01;
      @(negedge clk);
      check("miss suppress gnt1", req1_gnt, 0);
      check("miss no rsp", rsp_valid, 0);
      next();
      req1_en = 0; tlb_lru = 8'hFF;
      @(negedge clk);
      check("walk_req", walk_req, 1);
      check("walk_addr", walk_addr, 50'h1234);
      check("walk busy", busy, 1);
      next(); next();
      @(negedge clk); check("walk_req held", walk_req, 1);
      next();
      walk_ack = 1;
      @(negedge clk); check("walk_req at ack", walk_req, 1);
      next();
      walk_rsp_valid = 1; walk_rsp_data0 = 64'hAA; walk_rsp_data1 = 64'h55;
      @(negedge clk);
      check("walk_req dropped", walk_req, 0);
      check("wait no rsp", rsp_valid, 0);
      next();
      @(negedge clk);
      check("fill wen", tlb_write_wen, 1);
      check("fill way", tlb_write_way, 1);
      check("fill data0", tlb_write_data0, 64'hAA);
      check("fill data1", tlb_write_data1, 64'h55);
      check("fill addr", tlb_addr, 50'h1234);
      next();
      @(negedge clk);
      check("replay clkEn", tlb_read_clkEn, 1);
      check("replay addr", tlb_addr, 50'h1234);
      check("replay no wen", tlb_write_wen, 0);
      next();
      tlb_hit = 4'b0010;
      @(negedge clk);
      check("replay rsp_valid", rsp_valid, 1);
      check("replay rsp_port", rsp_port, 0);
      check("replay rsp_fault", rsp_fault, 0);
      check("replay idle", busy, 0);
      next();

      // ---- fault on port 1 ----
      req1_en = 1; req1_addr = 50'h777;
      @(negedge clk); check("fault grant1", req1_gnt, 1);
      next();
      req1_en = 0;
      next();
      walk_ack = 1;
      next();
      walk_rsp_valid = 1; walk_rsp_fault = 1;
      @(negedge clk);
      check("fault rsp_valid", rsp_valid, 1);
      check("fault rsp_fault", rsp_fault, 1);
      check("fault rsp_port", rsp_port, 1);
      check("fault no wen", tlb_write_wen, 0);
      next();
      @(negedge clk);
      check("fault idle", busy, 0);
      check("fault no wen after", tlb_write_wen, 0);
      check("fault rsp once", rsp_valid, 0);
      next();

      // ---- all LRU nonzero, ack and response in the same cycle ----
      req0_en = 1; req0_addr = 50'h2000;
      @(negedge clk); check("lruff grant0", req0_gnt, 1);
      next();
      req0_en = 0; tlb_lru = 8'hFF;
      next();
      walk_ack = 1; walk_rsp_valid = 1; walk_rsp_data0 = 64'h33; walk_rsp_data1 = 64'h66;
      @(negedge clk); check("ack+rsp no rsp_valid", rsp_valid, 0);
      next();
      @(negedge clk);
      check("lruff wen", tlb_write_wen, 1);
      check("lruff way", tlb_write_way, 0);
      check("lruff data0", tlb_write_data0, 64'h33);
      next();
      next();
      tlb_hit = 4'b1000;
      @(negedge clk);
      check("lruff replay rsp", rsp_valid, 1);
      check("lruff replay port", rsp_port, 0);
      next();

      // ---- flush pulse during WALK_WAIT ----
      req0_en = 1; req0_addr = 50'h3000;
      @(negedge clk); check("flush-case grant0", req0_gnt, 1);
      next();
      req1_en = 1; tlb_lru = 8'b00_01_01_01;
      @(negedge clk);
      check("flush-case miss gnt0", req0_gnt, 0);
      check("flush-case miss gnt1", req1_gnt, 0);
      next();
      walk_ack = 1;
      next();
      flush = 1;
      next();
      walk_rsp_valid = 1; walk_rsp_data0 = 64'h44;
      next();
      @(negedge clk);
      check("flush-case fill way", tlb_write_way, 3);
      check("flush-case no inval in fill", tlb_inval_en, 0);
      next();
      @(negedge clk); check("flush-case replay", tlb_read_clkEn, 1);
      next();
      tlb_hit = 4'b0001;
      @(negedge clk);
      check("flush-case replay rsp", rsp_valid, 1);
      check("flush-case gnt0 blocked", req0_gnt, 0);
      check("flush-case gnt1 blocked", req1_gnt, 0);
      next();
      for (int i = 0; i < 32; i++) begin
         if (i == 31) begin req0_en = 0; req1_en = 0; end
         @(negedge clk);
         check($sformatf("flush %0d inval_en", i), tlb_inval_en, 1);
         check($sformatf("flush %0d set", i), tlb_inval_set, i);
         check($sformatf("flush %0d gnt", i), {req0_gnt, req1_gnt}, 0);
         check($sformatf("flush %0d done", i), flush_done, 0);
         next();
      end
      @(negedge clk);
      check("flush_done pulse", flush_done, 1);
      check("flush end inval", tlb_inval_en, 0);
      check("flush end idle", busy, 0);
      next();
      @(negedge clk); check("flush_done single", flush_done, 0);
      next();

      // ---- reset during WALK_WAIT with rr left at 1 ----
      req1_en = 1; req1_addr = 50'h555;
      @(negedge clk); check("rst-case grant1", req1_gnt, 1);
      next();
      req1_en = 0;
      next();
      walk_ack = 1;
      next();
      @(negedge clk);
      check("rst-case in walk", busy, 1);
      #1 rst = 1'b0;
      #1;
      check("rst-case busy", busy, 0);
      check("rst-case walk_req", walk_req, 0);
      check("rst-case rsp_valid", rsp_valid, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      req0_en = 1; req1_en = 1; req0_addr = A0; req1_addr = A1;
      @(negedge clk);
      check("rst-case rr gnt1", req1_gnt, 1);
      check("rst-case rr gnt0", req0_gnt, 0);
      next();
      req0_en = 0; req1_en = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dwtlb_ctrl.md
Name: dwtlb_ctrl

Overview:
- Sequencer and arbiter for the 4-way, 32-set data write TLB.
- Shares the TLB read port between two store-address requesters using round-robin.
- Detects misses and runs the page-walk handshake, then writes the result into the victim way chosen from the per-way LRU fields.
- Replays the missed lookup and handles full-TLB invalidation.

Parameters:
- IP_WIDTH, 50, virtual page tag width (VA bits 62:13).
- DATA_WIDTH, `dtlbData_width, width of each translation payload half.
- SETS, 32, set count; set index is addr[4:0] (VA 17:13).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req0_en / req1_en  in  1  lookup request, ports 0 and 1
- req0_addr / req1_addr  in  IP_WIDTH  VA tag for each port
- req0_gnt / req1_gnt  out  1  request accepted this cycle
- tlb_read_clkEn  out  1  TLB read enable
- tlb_addr  out  IP_WIDTH  TLB lookup/fill address
- tlb_hit  in  4  per-way read_hit
- tlb_lru  in  8  per-way 2-bit LRU; way w uses bits [2w+1:2w]
- tlb_write_wen  out  1  fill write strobe
- tlb_write_way  out  2  fill way
- tlb_write_data0 / tlb_write_data1  out  DATA_WIDTH  fill payload
- tlb_inval_en  out  1  invalidate all ways of one set
- tlb_inval_set  out  5  set being invalidated
- walk_req  out  1  page-walk request, held until walk_ack
- walk_addr  out  IP_WIDTH  walk VA tag
- walk_ack  in  1  walker accepted request
- walk_rsp_valid  in  1  walk result strobe, one cycle
- walk_rsp_data0 / walk_rsp_data1  in  DATA_WIDTH  walk payload
- walk_rsp_fault  in  1  translation fault
- flush  in  1  invalidate-all request, pulse
- flush_done  out  1  one-cycle completion pulse
- rsp_valid  out  1  lookup result valid
- rsp_port  out  1  port the result belongs to
- rsp_fault  out  1  result is a fault; no translation
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr pointer=0, all outputs 0, in-flight lookup cleared.
- States: IDLE, WALK_REQ, WALK_WAIT, FILL, REPLAY, FLUSH.
- Grant rule:
  - Grants happen only in IDLE, and only when the stage-2 lookup is not a miss. This is a combinational suppression.
  - Round-robin: the port differing from rr wins when both request. rr flips to the granted port.
  - Only one grant per cycle.
  - The granted address drives tlb_addr with tlb_read_clkEn=1 in the same cycle.
- Lookup latency is 1 cycle.
  - In cycle N+1 the stage-2 register (valid, port, addr) is checked against tlb_hit.
  - Hit (any tlb_hit bit): rsp_valid=1, rsp_port, rsp_fault=0.
  - Miss: no rsp_valid; latch addr/port, move to WALK_REQ, and suppress gnt in N+1. Lookups are therefore never lost.
- WALK_REQ: walk_req=1, walk_addr=latched addr. On walk_ack go to WALK_WAIT. walk_req drops the cycle after ack.
- WALK_WAIT: wait for walk_rsp_valid.
  - With fault: rsp_valid=1, rsp_fault=1, rsp_port=latched port; return to IDLE.
  - Otherwise: capture payload and go to FILL.
- FILL, one cycle:
  - tlb_write_wen=1; tlb_addr=latched addr; tlb_write_data0/1=captured payload.
  - Way = lowest-index way with LRU==0, taken from the tlb_lru value sampled at the miss; if none, way 0.
  - Then go to REPLAY.
- REPLAY: tlb_read_clkEn=1 with latched addr, then return to IDLE.
  - The stage-2 check next cycle must hit and produces rsp_valid.
  - A replay miss restarts WALK_REQ, with no retry limit.
- FLUSH:
  - Entered from IDLE when flush=1. flush has priority over new grants, and an in-flight lookup completes first.
  - A flush arriving in a non-IDLE state is held pending until IDLE.
  - A 5-bit counter runs 0..31 with tlb_inval_en=1 and tlb_inval_set=counter, one set per cycle.
  - After set 31: flush_done=1 for one cycle, then IDLE. The counter wraps to 0.
- Simultaneous walk_ack and walk_rsp_valid in WALK_REQ is legal; the response is taken directly.
- busy = state≠IDLE.

Test Plan:
- Reset mid-WALK_WAIT (rst low 1 cycle) → state IDLE, walk_req=0, busy=0, no rsp_valid, next grant to port 1 (rr=0).
- Both ports request every cycle, all hits → grants alternate 1,0,1,0; rsp_valid each cycle from cycle 2, rsp_port matching grant order.
- Port0 addr 0x1234 misses with tlb_lru=8'b11_10_00_01 → walk_req with walk_addr=0x1234; ack after 3 cycles; rsp data0=0xAA → FILL with tlb_write_way=1, data0=0xAA; REPLAY hits → rsp_valid, rsp_port=0, rsp_fault=0.
- Miss with walk_rsp_fault=1 → no tlb_write_wen; rsp_valid=1, rsp_fault=1 in that cycle; IDLE next cycle.
- Miss with all LRU nonzero (8'hFF) → tlb_write_way=0.
- flush pulse during WALK_WAIT → completes walk/fill/replay, then 32 cycles tlb_inval_en with sets 0..31, flush_done pulse after set 31, no grants during flush.
